execute_cycle: RTL and testbench
================================

// Module: execute_cycle
// PURPOSE
//  Execute stage of the 24-bit five-stage pipeline; consumes decode_cycle's E-stage outputs.
//  Applies operand forwarding, runs the ALU, resolves branches, and registers the results into the E/M boundary.
//  An iterative multiply (ALUControlE=3'b111) holds the stage and raises StallE for the hazard unit.
// PARAMETERS
//  DW   24  datapath / PC width
//  RAW  5   destination register address width (matches RD_E)
// PORTS
//  clk          in   1    clock
//  rst          in   1    reset, asynchronous, active-low
//  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  in 1 each   E-stage control
//  ALUControlE  in   3    000 ADD,001 SUB,010 AND,011 OR,100 XOR,101 SLT(signed),110 SHL(B[4:0]),111 MUL
//  RD1_E, RD2_E in   DW   register operands
//  Imm_Ext_E    in   DW   extended immediate
//  RD_E         in   RAW  destination register
//  PCE          in   DW   PC of E-stage instruction
//  PCPlus4E     in   DW   PC+4 of E-stage instruction
//  ForwardAE, ForwardBE  in 2   00 RDx_E, 01 ResultW, 10 ALUResultM, 11 = RDx_E
//  ResultW      in   DW   writeback result (forward source)
//  PCSrcE       out  1    branch taken, redirect fetch (combinational)
//  PCTargetE    out  DW   PCE + Imm_Ext_E mod 2^DW (combinational)
//  StallE       out  1    multiply in progress; hold F/D/E (combinational)
//  RegWriteM, MemWriteM, ResultSrcM  out 1 each   registered control
//  ALUResultM   out  DW   registered ALU / product
//  WriteDataM   out  DW   registered forwarded B operand, pre-immediate mux
//  RD_M         out  RAW  registered destination
//  PCPlus4M     out  DW   registered PC+4
// BEHAVIOUR
//  Reset (rst=0, async): all M outputs 0, FSM IDLE, counter 0; StallE=0 and PCSrcE=0 while held.
//  SrcA = fwd(ForwardAE); WriteData = fwd(ForwardBE); SrcB = ALUSrcE ? Imm_Ext_E : WriteData.
//  ALU ops: arithmetic mod 2^DW, no overflow flag; SLT gives 1/0; Zero = (ALUResult==0).
//  PCSrcE = BranchE & Zero & ~StallE.
//  Non-MUL latency: 1 cycle, E inputs to M registers on the next rising edge.
//  MUL FSM, shift-add, low DW bits of product, unsigned:
//   IDLE: ALUControlE==111 -> latch SrcA/SrcB, cnt=0, StallE=1, M gets bubble -> BUSY.
//   BUSY: one partial product per cycle, StallE=1, M gets bubble;
//     cnt==DW-1 -> DONE, else cnt++.
//   DONE: StallE=0; M captures product and MUL's control/RD_M -> IDLE.
//   StallE is high for DW+1 = 25 cycles; the product is in ALUResultM DW+2 cycles after MUL enters E.
//  Bubble means RegWriteM=MemWriteM=ResultSrcM=0; other M fields are don't-care.
//  Operands are latched at the MUL entry cycle, so later ResultW/ALUResultM changes do not affect the product.
//  E-stage inputs are held stable by the hazard unit while StallE=1; block ignores them until DONE.
//  Reset mid-multiply: abort to IDLE, no partial result emitted.
// STRUCTURE
//  isa_pkg: alu_op_t enum (8 codes), fwd_sel_t (00/01/10), MUL_CYCLES = DW.
//  Sub-module mul_iter: start/busy/done handshake, DW-bit operands, DW-bit product.
//  Top-level contains the forwarding muxes, ALU, branch logic, and E/M register.
// TESTING
//  ADD, RD1=0x000005, RD2=0x000003, Fwd=00 -> next cycle ALUResultM=0x000008, RegWriteM=1.
//  SUB 0x000000-0x000001 -> 0xFFFFFF; SLT(-1,1)=1; SHL 0x000001 by 23 -> 0x800000.
//  Forwarding: ForwardAE=10 with ALUResultM=0x00000A, ForwardBE=01 with ResultW=0x000002, ADD -> 0x00000C.
//  BEQ: BranchE=1, operands equal, PCE=0x000100, Imm=0xFFFFF0 -> PCSrcE=1, PCTargetE=0x0000F0.
//  MUL 0x000123*0x000010:
//   StallE high exactly 25 cycles; RegWriteM=0 throughout; then ALUResultM=0x001230.
//   Product 0x800000*2 wraps to 0.
//  Reset asserted in BUSY cycle 10:
//   M outputs 0 and StallE=0 immediately.
//   After release, ADD 1+1 -> 0x000002 in one cycle.

Source files
------------

// File: rtl/execute_cycle_pkg.sv
// Shared types and constants for the execute stage of the 24-bit pipeline.
// ALU opcodes, forwarding selects, multiplier FSM states and the forwarding mux helper.
package execute_cycle_pkg;

   localparam int unsigned DW         = 24;
   localparam int unsigned RAW        = 5;
   localparam int unsigned MUL_CYCLES = DW;
   localparam int unsigned CntW       = $clog2(MUL_CYCLES);
   localparam int unsigned ShAmtW     = $clog2(DW);

   typedef enum logic [2:0] {
      AluAdd = 3'b000,
      AluSub = 3'b001,
      AluAnd = 3'b010,
      AluOr  = 3'b011,
      AluXor = 3'b100,
      AluSlt = 3'b101,
      AluShl = 3'b110,
      AluMul = 3'b111
   } alu_op_t;

   typedef enum logic [1:0] {
      FwdReg     = 2'b00,
      FwdResultW = 2'b01,
      FwdAluM    = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } mul_state_t;

   // Select code 2'b11 falls back to the register-file operand.
   function automatic logic [DW-1:0] fwd_mux(input fwd_sel_t sel, input logic [DW-1:0] rf,
                                             input logic [DW-1:0] wb, input logic [DW-1:0] mem);
      case (sel)
         FwdResultW: return wb;
         FwdAluM:    return mem;
         default:    return rf;
      endcase
   endfunction

endpackage

// File: rtl/execute_cycle_if.sv
// E-stage inputs and E/M outputs of the execute stage, bundled for the decode/memory sides.
// The slave modport is the execute stage itself; master is the surrounding pipeline.
interface execute_cycle_if;
   import execute_cycle_pkg::*;

   logic            RegWriteE;
   logic            ALUSrcE;
   logic            MemWriteE;
   logic            ResultSrcE;
   logic            BranchE;
   logic [2:0]      ALUControlE;
   logic [DW-1:0]   RD1_E;
   logic [DW-1:0]   RD2_E;
   logic [DW-1:0]   Imm_Ext_E;
   logic [RAW-1:0]  RD_E;
   logic [DW-1:0]   PCE;
   logic [DW-1:0]   PCPlus4E;
   logic [1:0]      ForwardAE;
   logic [1:0]      ForwardBE;
   logic [DW-1:0]   ResultW;

   logic            PCSrcE;
   logic [DW-1:0]   PCTargetE;
   logic            StallE;
   logic            RegWriteM;
   logic            MemWriteM;
   logic            ResultSrcM;
   logic [DW-1:0]   ALUResultM;
   logic [DW-1:0]   WriteDataM;
   logic [RAW-1:0]  RD_M;
   logic [DW-1:0]   PCPlus4M;

   modport master (
      output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
      output RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E, ForwardAE, ForwardBE, ResultW,
      input  PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM,
      input  ALUResultM, WriteDataM, RD_M, PCPlus4M
   );

   modport slave (
      input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
      input  RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E, ForwardAE, ForwardBE, ResultW,
      output PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM,
      output ALUResultM, WriteDataM, RD_M, PCPlus4M
   );

endinterface

// File: rtl/execute_cycle_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, low DW bits of an unsigned product.
// busy covers the start cycle and every BUSY cycle; done marks the single cycle the product is valid.
module execute_cycle_mul_iter
   import execute_cycle_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] product
);

   localparam logic [CntW-1:0] CntLast = CntW'(MUL_CYCLES - 1);

   mul_state_t      state_q, state_d;
   logic [DW-1:0]   a_q, b_q, acc_q;
   logic [CntW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StBusy;
         StBusy:  if (cnt_q == CntLast) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Gated by rst so the stall drops while reset is held, even with a MUL presented.
   always_comb begin
      busy    = rst & (((state_q == StIdle) & start) | (state_q == StBusy));
      done    = rst & (state_q == StDone);
      product = acc_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
      end else if ((state_q == StIdle) && start) begin
         a_q   <= a;
         b_q   <= b;
         acc_q <= '0;
         cnt_q <= '0;
      end else if (state_q == StBusy) begin
         acc_q <= acc_q + (b_q[0] ? a_q : '0);
         a_q   <= a_q << 1;
         b_q   <= b_q >> 1;
         if (cnt_q != CntLast) cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, branch resolution and the E/M pipeline register.
// MUL runs on the iterative multiplier and stalls the front of the pipe until its product is ready.
module execute_cycle
   import execute_cycle_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   execute_cycle_if.slave bus
);

   alu_op_t        alu_op;
   logic [DW-1:0]  src_a, src_b, write_data, alu_result, product;
   logic           zero, stall, mul_done;

   logic           reg_write_q, mem_write_q, result_src_q;
   logic [DW-1:0]  alu_result_q, write_data_q, pc_plus4_q;
   logic [RAW-1:0] rd_q;

   assign alu_op     = alu_op_t'(bus.ALUControlE);
   assign src_a      = fwd_mux(fwd_sel_t'(bus.ForwardAE), bus.RD1_E, bus.ResultW, alu_result_q);
   assign write_data = fwd_mux(fwd_sel_t'(bus.ForwardBE), bus.RD2_E, bus.ResultW, alu_result_q);
   assign src_b      = bus.ALUSrcE ? bus.Imm_Ext_E : write_data;

   always_comb begin
      alu_result = '0;
      unique case (alu_op)
         AluAdd: alu_result = src_a + src_b;
         AluSub: alu_result = src_a - src_b;
         AluAnd: alu_result = src_a & src_b;
         AluOr:  alu_result = src_a | src_b;
         AluXor: alu_result = src_a ^ src_b;
         AluSlt: alu_result = {{(DW-1){1'b0}}, $signed(src_a) < $signed(src_b)};
         AluShl: alu_result = src_a << src_b[ShAmtW-1:0];
         AluMul: alu_result = '0;
      endcase
   end

   assign zero = (alu_result == '0);

   execute_cycle_mul_iter u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (alu_op == AluMul),
      .a       (src_a),
      .b       (src_b),
      .busy    (stall),
      .done    (mul_done),
      .product (product)
   );

   assign bus.StallE    = stall;
   assign bus.PCSrcE    = rst & bus.BranchE & zero & ~stall;
   assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;

   // Data fields hold during a stall so ALUResultM stays a valid forward source for the MUL.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reg_write_q  <= 1'b0;
         mem_write_q  <= 1'b0;
         result_src_q <= 1'b0;
         alu_result_q <= '0;
         write_data_q <= '0;
         rd_q         <= '0;
         pc_plus4_q   <= '0;
      end else begin
         reg_write_q  <= bus.RegWriteE & ~stall;
         mem_write_q  <= bus.MemWriteE & ~stall;
         result_src_q <= bus.ResultSrcE & ~stall;
         if (!stall) begin
            alu_result_q <= mul_done ? product : alu_result;
            write_data_q <= write_data;
            rd_q         <= bus.RD_E;
            pc_plus4_q   <= bus.PCPlus4E;
         end
      end
   end

   assign bus.RegWriteM  = reg_write_q;
   assign bus.MemWriteM  = mem_write_q;
   assign bus.ResultSrcM = result_src_q;
   assign bus.ALUResultM = alu_result_q;
   assign bus.WriteDataM = write_data_q;
   assign bus.RD_M       = rd_q;
   assign bus.PCPlus4M   = pc_plus4_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Scoreboard bench for execute_cycle: directed cases plus random instructions against a
// plain-arithmetic reference model; a negedge monitor checks every committed instruction.
module tb_execute_cycle;
   import execute_cycle_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   execute_cycle_if bus ();

   execute_cycle dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int             tag;
      logic [DW-1:0]  alu;
      logic [DW-1:0]  wd;
      logic [DW-1:0]  pc4;
      logic [RAW-1:0] rd;
      logic           memw;
      logic           rsrc;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          mon_e;
   int            total = 0;
   int            bad   = 0;
   int            tag   = 0;
   logic [DW-1:0] model_m = '0;

   task automatic check(input string name, input int t, input logic [DW-1:0] got,
                        input logic [DW-1:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s tag=%0d got=%h want=%h", name, t, got, want);
      end
   endtask

   function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
      logic [2*DW-1:0] p;
      logic [DW-1:0]   r;
      case (op)
         3'd0: r = a + b;
         3'd1: r = a - b;
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = ($signed(a) < $signed(b)) ? DW'(1) : '0;
         3'd6: r = a << b[4:0];
         default: begin
            p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
            r = p[DW-1:0];
         end
      endcase
      return r;
   endfunction

   function automatic logic [DW-1:0] fwd_model(input logic [1:0] sel, input logic [DW-1:0] rf,
                                               input logic [DW-1:0] wb, input logic [DW-1:0] mem);
      if (sel == 2'b01) return wb;
      if (sel == 2'b10) return mem;
      return rf;
   endfunction

   task automatic drive(input logic [2:0] op, input logic [DW-1:0] rd1, input logic [DW-1:0] rd2,
                        input logic [DW-1:0] imm, input logic alusrc, input logic [1:0] fa,
                        input logic [1:0] fb, input logic [DW-1:0] resw, input logic br,
                        input logic [DW-1:0] pce, input logic [RAW-1:0] rd, input logic rw,
                        input logic memw, input logic rsrc);
      bus.ALUControlE = op;
      bus.RD1_E       = rd1;
      bus.RD2_E       = rd2;
      bus.Imm_Ext_E   = imm;
      bus.ALUSrcE     = alusrc;
      bus.ForwardAE   = fa;
      bus.ForwardBE   = fb;
      bus.ResultW     = resw;
      bus.BranchE     = br;
      bus.PCE         = pce;
      bus.PCPlus4E    = pce + DW'(4);
      bus.RD_E        = rd;
      bus.RegWriteE   = rw;
      bus.MemWriteE   = memw;
      bus.ResultSrcE  = rsrc;
   endtask

   task automatic nop();
      @(posedge clk);
      #1;
      drive(3'd0, '0, '0, '0, 1'b0, 2'b00, 2'b00, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      model_m = '0;
   endtask

   task automatic issue(input logic [2:0] op, input logic [DW-1:0] rd1, input logic [DW-1:0] rd2,
                        input logic [DW-1:0] imm, input logic alusrc, input logic [1:0] fa,
                        input logic [1:0] fb, input logic [DW-1:0] resw, input logic br,
                        input logic [DW-1:0] pce, input logic [RAW-1:0] rd, input logic memw,
                        input logic rsrc, input bit use_k, input logic [DW-1:0] k);
      exp_t          e;
      logic [DW-1:0] a, b, wd, r;
      int            n, bub;
      @(posedge clk);
      #1;
      drive(op, rd1, rd2, imm, alusrc, fa, fb, resw, br, pce, rd, 1'b1, memw, rsrc);
      a  = fwd_model(fa, rd1, resw, model_m);
      wd = fwd_model(fb, rd2, resw, model_m);
      b  = alusrc ? imm : wd;
      r  = use_k ? k : ref_alu(op, a, b);
      tag++;
      e = '{tag, r, wd, pce + DW'(4), rd, memw, rsrc};
      if (op == 3'b111) begin
         n   = 0;
         bub = 0;
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.StallE) break;
            if (i > 0 && bus.RegWriteM) bub++;
            n++;
         end
         check("mul_stall_cycles", tag, DW'(n), DW'(MUL_CYCLES + 1));
         check("mul_bubble", tag, DW'(bub), '0);
      end else begin
         @(negedge clk);
         check("stall", tag, DW'(bus.StallE), '0);
         check("pc_target", tag, bus.PCTargetE, pce + imm);
         check("pc_src", tag, DW'(bus.PCSrcE), DW'(br && (r == '0)));
      end
      exp_q.push_back(e);
      model_m = r;
   endtask

   always @(negedge clk) begin
      if (rst && bus.RegWriteM) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_commit got alu=%h want=no commit", bus.ALUResultM);
         end else begin
            mon_e = exp_q.pop_front();
            check("alu_result", mon_e.tag, bus.ALUResultM, mon_e.alu);
            check("write_data", mon_e.tag, bus.WriteDataM, mon_e.wd);
            check("pc_plus4", mon_e.tag, bus.PCPlus4M, mon_e.pc4);
            check("rd", mon_e.tag, DW'(bus.RD_M), DW'(mon_e.rd));
            check("mem_write", mon_e.tag, DW'(bus.MemWriteM), DW'(mon_e.memw));
            check("result_src", mon_e.tag, DW'(bus.ResultSrcM), DW'(mon_e.rsrc));
         end
      end
   end

   initial begin
      logic [2:0] rop;
      // MUL + branch presented during reset: stall and redirect must stay low
      drive(3'b111, 24'h000123, 24'h000010, '0, 1'b0, 2'b00, 2'b00, '0, 1'b1, 24'h000040, 5'd3,
            1'b1, 1'b1, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stall", 0, DW'(bus.StallE), '0);
      check("rst_pcsrc", 0, DW'(bus.PCSrcE), '0);
      check("rst_regwrite", 0, DW'(bus.RegWriteM), '0);
      check("rst_alu", 0, bus.ALUResultM, '0);
      check("rst_rd", 0, DW'(bus.RD_M), '0);
      drive(3'd0, '0, '0, '0, 1'b0, 2'b00, 2'b00, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      model_m = '0;
      rst = 1'b1;

      issue(3'd0, 24'h000005, 24'h000003, '0, 1'b0, 2'b00, 2'b00, '0, 1'b0, 24'h10, 5'd1, 0, 0, 1,
            24'h000008);
      issue(3'd1, 24'h000000, 24'h000001, '0, 1'b0, 2'b00, 2'b00, '0, 1'b0, 24'h14, 5'd2, 1, 0, 1,
            24'hFFFFFF);
      issue(3'd5, 24'hFFFFFF, 24'h000001, '0, 1'b0, 2'b00, 2'b00, '0, 1'b0, 24'h18, 5'd3, 0, 1, 1,
            24'h000001);
      issue(3'd6, 24'h000001, 24'd23, '0, 1'b0, 2'b00, 2'b00, '0, 1'b0, 24'h1C, 5'd4, 0, 0, 1,
            24'h800000);
      issue(3'd0, 24'h000007, 24'h000003, '0, 1'b0, 2'b00, 2'b00, '0, 1'b0, 24'h20, 5'd5, 0, 0, 1,
            24'h00000A);
      issue(3'd0, 24'h000055, 24'h000066, '0, 1'b0, 2'b10, 2'b01, 24'h000002, 1'b0, 24'h24, 5'd6,
            0, 0, 1, 24'h00000C);
      issue(3'd1, 24'h000042, 24'h000042, 24'hFFFFF0, 1'b0, 2'b00, 2'b00, '0, 1'b1, 24'h000100,
            5'd7, 0, 0, 0, '0);
      issue(3'd1, 24'h000005, 24'h000003, 24'h000008, 1'b0, 2'b00, 2'b00, '0, 1'b1, 24'h104,
            5'd8, 0, 0, 0, '0);
      issue(3'd0, 24'h000100, 24'h0000AA, 24'h000020, 1'b1, 2'b00, 2'b00, '0, 1'b0, 24'h108,
            5'd9, 1, 0, 0, '0);
      issue(3'd7, 24'h000123, 24'h000010, '0, 1'b0, 2'b00, 2'b00, '0, 1'b0, 24'h10C, 5'd10, 0, 1,
            1, 24'h001230);
      issue(3'd7, 24'h800000, 24'h000002, '0, 1'b0, 2'b00, 2'b00, '0, 1'b0, 24'h110, 5'd11, 0, 0,
            1, 24'h000000);

      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         issue(rop, 24'($urandom), 24'($urandom), 24'($urandom), 1'($urandom), 2'($urandom),
               2'($urandom), 24'($urandom), 1'($urandom), 24'($urandom), 5'($urandom),
               1'($urandom), 1'($urandom), 0, '0);
      end

      // Reset during BUSY cycle 10 of a multiply
      nop();
      @(posedge clk);
      #1;
      drive(3'b111, 24'h000123, 24'h000010, '0, 1'b0, 2'b00, 2'b00, '0, 1'b1, 24'h200, 5'd12,
            1'b1, 1'b1, 1'b1);
      repeat (11) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("abort_stall", 0, DW'(bus.StallE), '0);
      check("abort_pcsrc", 0, DW'(bus.PCSrcE), '0);
      check("abort_regwrite", 0, DW'(bus.RegWriteM), '0);
      check("abort_alu", 0, bus.ALUResultM, '0);
      check("abort_wd", 0, bus.WriteDataM, '0);
      check("abort_pc4", 0, bus.PCPlus4M, '0);
      drive(3'd0, '0, '0, '0, 1'b0, 2'b00, 2'b00, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      model_m = '0;
      @(negedge clk);
      rst = 1'b1;
      issue(3'd0, 24'h000001, 24'h000001, '0, 1'b0, 2'b00, 2'b00, '0, 1'b0, 24'h300, 5'd13, 0, 0,
            1, 24'h000002);

      nop();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("drain", 0, DW'(exp_q.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
